// File: rtl/assoc_extract_buffer_if.sv
// rtl/assoc_extract_buffer_if.sv - write/extract/response bus of the associative extract buffer
// rd_peek exists only when ASSOC_EXTRACT_PEEK_EN is defined.
interface assoc_extract_buffer_if #(
  parameter int KEY_SIZE    = 4,
  parameter int DATA_SIZE   = 4,
  parameter int BUFFER_SIZE = 4
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [KEY_SIZE-1:0]  wr_key;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [KEY_SIZE-1:0]  rd_key;
`ifdef ASSOC_EXTRACT_PEEK_EN
  logic                 rd_peek;
`endif
  logic                 rsp_valid;
  logic                 rsp_hit;
  logic [DATA_SIZE-1:0] rsp_data;
  logic [CW-1:0]        count;
  logic                 full;

  modport master (
    output wr_valid, wr_key, wr_data, rd_valid, rd_key
`ifdef ASSOC_EXTRACT_PEEK_EN
    , output rd_peek
`endif
    , input wr_ready, rd_ready, rsp_valid, rsp_hit, rsp_data, count, full
  );

  modport slave (
    input wr_valid, wr_key, wr_data, rd_valid, rd_key
`ifdef ASSOC_EXTRACT_PEEK_EN
    , input rd_peek
`endif
    , output wr_ready, rd_ready, rsp_valid, rsp_hit, rsp_data, count, full
  );
endinterface

// File: rtl/assoc_extract_buffer.sv
// rtl/assoc_extract_buffer.sv - key/data store with extract-by-key and compaction
// Optional ASSOC_EXTRACT_PEEK_EN adds non-destructive lookups via rd_peek.
module assoc_extract_buffer #(
  parameter int KEY_SIZE    = 4,
  parameter int DATA_SIZE   = 4,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                  clk_i,
  input  logic                  async_reset_i,
  assoc_extract_buffer_if.slave bus
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int IW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e               state_q, state_d;
  logic [BUFFER_SIZE-1:0] valid_q, valid_d;
  logic [KEY_SIZE-1:0]  key_q  [BUFFER_SIZE];
  logic [KEY_SIZE-1:0]  key_d  [BUFFER_SIZE];
  logic [DATA_SIZE-1:0] data_q [BUFFER_SIZE];
  logic [DATA_SIZE-1:0] data_d [BUFFER_SIZE];
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;

  logic          rd_hit, wr_hit, rd_fire, wr_fire, peek, full;
  logic [IW-1:0] rd_idx, wr_idx, ptr_nxt, tail_idx;

`ifdef ASSOC_EXTRACT_PEEK_EN
  assign peek = bus.rd_peek;
`else
  assign peek = 1'b0;
`endif

  assign full     = (count_q == CW'(BUFFER_SIZE));
  assign tail_idx = count_q[IW-1:0];
  assign ptr_nxt  = ptr_q + IW'(1);

  // Reads take priority: a pending read blocks the write side for this cycle.
  assign bus.rd_ready  = (state_q == ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_IDLE) && !bus.rd_valid;
  assign rd_fire       = bus.rd_valid && bus.rd_ready;
  assign wr_fire       = bus.wr_valid && bus.wr_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.count     = count_q;
  assign bus.full      = full;

  // Descending scan so the lowest matching slot is the one left selected.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == bus.rd_key) begin
        rd_hit = 1'b1;
        rd_idx = IW'(i);
      end
      if (valid_q[i] && key_q[i] == bus.wr_key) begin
        wr_hit = 1'b1;
        wr_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    key_d       = key_q;
    data_d      = data_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (rd_fire) begin
          rsp_valid_d = 1'b1;
          if (rd_hit) begin
            rsp_hit_d  = 1'b1;
            rsp_data_d = data_q[rd_idx];
            if (!peek) begin
              valid_d[rd_idx] = 1'b0;
              key_d[rd_idx]   = '0;
              data_d[rd_idx]  = '0;
              count_d         = count_q - CW'(1);
              // Removing the tail slot leaves nothing to close up.
              if (CW'(rd_idx) != count_q - CW'(1)) begin
                state_d = ST_SHIFT;
                ptr_d   = rd_idx;
              end
            end
          end
        end else if (wr_fire) begin
          if (wr_hit) begin
            data_d[wr_idx] = bus.wr_data;
          end else if (!full) begin
            valid_d[tail_idx] = 1'b1;
            key_d[tail_idx]   = bus.wr_key;
            data_d[tail_idx]  = bus.wr_data;
            count_d           = count_q + CW'(1);
          end
        end
      end
      ST_SHIFT: begin
        valid_d[ptr_q]   = valid_q[ptr_nxt];
        key_d[ptr_q]     = key_q[ptr_nxt];
        data_d[ptr_q]    = data_q[ptr_nxt];
        valid_d[ptr_nxt] = 1'b0;
        key_d[ptr_nxt]   = '0;
        data_d[ptr_nxt]  = '0;
        // count_q already excludes the removed entry, so it names the old tail.
        if (CW'(ptr_nxt) == count_q) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      key_q       <= key_d;
      data_q      <= data_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_assoc_extract_buffer.sv
// tb/tb_assoc_extract_buffer.sv - self-checking bench for assoc_extract_buffer
// Directed vector table, hand sequences (peek, reset mid-compaction), random run against a queue model.
module tb_assoc_extract_buffer;
  localparam int KS = 4;
  localparam int DS = 4;
  localparam int BS = 4;
`ifdef ASSOC_EXTRACT_PEEK_EN
  localparam bit PEEK = 1'b1;
`else
  localparam bit PEEK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  assoc_extract_buffer_if #(.KEY_SIZE(KS), .DATA_SIZE(DS), .BUFFER_SIZE(BS)) bus ();

  assoc_extract_buffer #(.KEY_SIZE(KS), .DATA_SIZE(DS), .BUFFER_SIZE(BS)) dut (
    .clk_i         (clk),
    .async_reset_i (rst),
    .bus           (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int rv, rk, wv, wk, wd;
    int e_rr, e_wr, e_rsp, e_hit, e_data, e_cnt, e_full;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(int rv, int rk, int wv, int wk, int wd, int e_rr, int e_wr,
                              int e_rsp, int e_hit, int e_data, int e_cnt, int e_full);
    vec_t v;
    v.rv = rv; v.rk = rk; v.wv = wv; v.wk = wk; v.wd = wd;
    v.e_rr = e_rr; v.e_wr = e_wr; v.e_rsp = e_rsp; v.e_hit = e_hit;
    v.e_data = e_data; v.e_cnt = e_cnt; v.e_full = e_full;
    return v;
  endfunction

  typedef struct { logic [KS-1:0] k; logic [DS-1:0] d; } ent_t;
  ent_t mq[$];
  int   m_busy = 0;

  task automatic drive(input bit rv, input logic [KS-1:0] rk, input bit pk,
                       input bit wv, input logic [KS-1:0] wk, input logic [DS-1:0] wd);
    bus.rd_valid = rv;
    bus.rd_key   = rk;
    bus.wr_valid = wv;
    bus.wr_key   = wk;
    bus.wr_data  = wd;
`ifdef ASSOC_EXTRACT_PEEK_EN
    bus.rd_peek  = pk;
`else
    if (pk) $display("peek requested without peek support");
`endif
  endtask

  // One cycle against the model: the buffer is an ordered list, extract removes
  // the first key match and blocks the bus for (len-1-index) cycles.
  task automatic mstep(input bit rv, input logic [KS-1:0] rk, input bit pk,
                       input bit wv, input logic [KS-1:0] wk, input logic [DS-1:0] wd);
    int   h;
    bit   e_rsp, e_hit, e_rr, e_wr;
    int   e_data;
    ent_t e;
    e_rsp = 0; e_hit = 0; e_data = 0; h = -1;
    drive(rv, rk, pk, wv, wk, wd);
    #1;
    e_rr = (m_busy == 0);
    e_wr = e_rr && !rv;
    chk("rd_ready", 32'(bus.rd_ready), 32'(e_rr));
    chk("wr_ready", 32'(bus.wr_ready), 32'(e_wr));
    if (m_busy > 0) begin
      m_busy--;
    end else if (rv) begin
      e_rsp = 1;
      foreach (mq[j]) if (h < 0 && mq[j].k == rk) h = j;
      if (h >= 0) begin
        e_hit  = 1;
        e_data = int'(mq[h].d);
        if (!pk) begin
          m_busy = mq.size() - 1 - h;
          mq.delete(h);
        end
      end
    end else if (wv) begin
      foreach (mq[j]) if (h < 0 && mq[j].k == wk) h = j;
      if (h >= 0) mq[h].d = wd;
      else if (mq.size() < BS) begin
        e.k = wk;
        e.d = wd;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
    chk("rsp_hit", 32'(bus.rsp_hit), 32'(e_hit));
    chk("rsp_data", 32'(bus.rsp_data), 32'(e_data));
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("full", 32'(bus.full), 32'(mq.size() == BS));
  endtask

  initial begin
    drive(0, 4'h0, 0, 0, 4'h0, 4'h0);
    #2;
    chk("reset count", 32'(bus.count), 0);
    chk("reset full", 32'(bus.full), 0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset rsp_data", 32'(bus.rsp_data), 0);
    chk("reset rd_ready", 32'(bus.rd_ready), 1);
    chk("reset wr_ready", 32'(bus.wr_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // rv rk wv wk wd | rr wr | rsp hit data cnt full
    vt.push_back(mk(0, 0,   1, 'hA, 3,  1, 1,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0,   1, 'hB, 5,  1, 1,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 0,   1, 'hC, 7,  1, 1,  0, 0, 0, 3, 0));
    vt.push_back(mk(1, 'hB, 0, 0,   0,  1, 0,  1, 1, 5, 2, 0));
    vt.push_back(mk(0, 0,   0, 0,   0,  0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(1, 'hF, 0, 0,   0,  1, 0,  1, 0, 0, 2, 0));
    vt.push_back(mk(1, 'hC, 0, 0,   0,  1, 0,  1, 1, 7, 1, 0));
    vt.push_back(mk(0, 0,   1, 'hB, 5,  1, 1,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 0,   1, 'hC, 7,  1, 1,  0, 0, 0, 3, 0));
    vt.push_back(mk(0, 0,   1, 'hD, 1,  1, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(0, 0,   1, 'hE, 2,  1, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(0, 0,   1, 'hA, 9,  1, 1,  0, 0, 0, 4, 1));
    vt.push_back(mk(1, 'hA, 0, 0,   0,  1, 0,  1, 1, 9, 3, 0));
    vt.push_back(mk(0, 0,   0, 0,   0,  0, 0,  0, 0, 0, 3, 0));
    vt.push_back(mk(0, 0,   0, 0,   0,  0, 0,  0, 0, 0, 3, 0));
    vt.push_back(mk(0, 0,   0, 0,   0,  0, 0,  0, 0, 0, 3, 0));
    vt.push_back(mk(1, 'hB, 1, 'hE, 4,  1, 0,  1, 1, 5, 2, 0));
    vt.push_back(mk(0, 0,   1, 'hE, 4,  0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 0,   1, 'hE, 4,  0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 0,   1, 'hE, 4,  1, 1,  0, 0, 0, 3, 0));
    vt.push_back(mk(1, 'hE, 0, 0,   0,  1, 0,  1, 1, 4, 2, 0));
    vt.push_back(mk(1, 'hD, 0, 0,   0,  1, 0,  1, 1, 1, 1, 0));
    vt.push_back(mk(1, 'hC, 0, 0,   0,  1, 0,  1, 1, 7, 0, 0));
    vt.push_back(mk(1, 'hC, 0, 0,   0,  1, 0,  1, 0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rv[0], vt[i].rk[KS-1:0], 1'b0, vt[i].wv[0], vt[i].wk[KS-1:0], vt[i].wd[DS-1:0]);
      #1;
      chk($sformatf("v%0d rd_ready", i), 32'(bus.rd_ready), vt[i].e_rr);
      chk($sformatf("v%0d wr_ready", i), 32'(bus.wr_ready), vt[i].e_wr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), vt[i].e_rsp);
      chk($sformatf("v%0d rsp_hit", i), 32'(bus.rsp_hit), vt[i].e_hit);
      chk($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), vt[i].e_data);
      chk($sformatf("v%0d count", i), 32'(bus.count), vt[i].e_cnt);
      chk($sformatf("v%0d full", i), 32'(bus.full), vt[i].e_full);
    end

`ifdef ASSOC_EXTRACT_PEEK_EN
    mstep(0, 4'h0, 0, 1, 4'hB, 4'd5);
    for (int i = 0; i < 2; i++) begin
      mstep(1, 4'hB, 1, 0, 4'h0, 4'h0);
      chk("peek hit", 32'(bus.rsp_hit), 1);
      chk("peek data", 32'(bus.rsp_data), 5);
      chk("peek count", 32'(bus.count), 1);
    end
    mstep(1, 4'hB, 0, 0, 4'h0, 4'h0);
`endif

    // Reset during the second compaction cycle of a slot-0 extract from a full buffer.
    mstep(0, 4'h0, 0, 1, 4'h1, 4'd1);
    mstep(0, 4'h0, 0, 1, 4'h2, 4'd2);
    mstep(0, 4'h0, 0, 1, 4'h3, 4'd3);
    mstep(0, 4'h0, 0, 1, 4'h4, 4'd4);
    mstep(1, 4'h1, 0, 0, 4'h0, 4'h0);
    mstep(0, 4'h0, 0, 0, 4'h0, 4'h0);
    chk("mid-shift rd_ready", 32'(bus.rd_ready), 0);
    rst = 1'b1;
    #1;
    chk("async count", 32'(bus.count), 0);
    chk("async rsp_valid", 32'(bus.rsp_valid), 0);
    chk("async rd_ready", 32'(bus.rd_ready), 1);
    chk("async wr_ready", 32'(bus.wr_ready), 1);
    mq.delete();
    m_busy = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mstep(1, 4'h2, 0, 0, 4'h0, 4'h0);

    for (int n = 0; n < 400; n++) begin
      mstep($urandom_range(0, 9) < 4, 4'($urandom_range(0, 5)), PEEK && ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/assoc_extract_buffer.md
Name: assoc_extract_buffer

Overview:
- Reader-side companion to the associative insert/update buffer: holds key/data pairs and serves read-and-remove (extract) requests by key.
- After each removal it compacts storage so valid entries stay contiguous in slots 0..count-1. Inserting blocks can therefore keep appending at index count.
- Sits between a producer that writes key/data pairs and a consumer that pulls them out by key over a valid/ready handshake.

Parameters:
KEY_SIZE, 4, key width in bits
DATA_SIZE, 4, data width in bits
BUFFER_SIZE, 4, number of entries (>=2)

Ports:
clk  in  1  clock, rising edge
async_reset  in  1  asynchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
wr_key  in  KEY_SIZE  write key
wr_data  in  DATA_SIZE  write data
rd_valid  in  1  extract request
rd_ready  out  1  extract accepted this cycle when rd_valid && rd_ready
rd_key  in  KEY_SIZE  extract key
rsp_valid  out  1  one-cycle response pulse
rsp_hit  out  1  key was found (qualified by rsp_valid)
rsp_data  out  DATA_SIZE  extracted data; 0 on miss
count  out  $clog2(BUFFER_SIZE+1)  number of valid entries
full  out  1  count == BUFFER_SIZE

Behaviour:
- Reset (asynchronous, immediate) clears:
  - all valid bits, keys and data;
  - count=0, state=IDLE;
  - rsp_valid=0, rsp_hit=0, rsp_data=0.
- Reset mid-SHIFT aborts compaction; the buffer is empty afterwards.
- Outputs after reset: wr_ready=1, rd_ready=1.
- States:
  - IDLE: rd_ready=1; wr_ready=!rd_valid, so a read wins over a simultaneous write.
  - SHIFT: rd_ready=0, wr_ready=0.
- Extract accepted in IDLE: combinational match over slots 0..count-1 against rd_key (lowest matching index wins). Next edge:
  - Hit at index h: rsp_valid=1, rsp_hit=1, rsp_data=data[h]; slot h invalidated; count decremented.
    - If h < count-1: enter SHIFT with pointer p=h.
    - If h == count-1: remain in IDLE.
  - Miss: rsp_valid=1, rsp_hit=0, rsp_data=0; no state change.
- Response latency: 1 cycle after acceptance. rsp_valid is high for exactly one cycle; there is no backpressure on the response.
- SHIFT: each cycle copy slot p+1 (key, data, valid) into slot p and clear slot p+1, then p=p+1.
  - Return to IDLE on the cycle the last valid slot (old count-1) has moved.
  - Compaction takes (old_count-1-h) cycles.
- Write accepted in IDLE, resolved next edge:
  - Key present at index k: data[k]=wr_data (update); count unchanged.
  - Key absent and count<BUFFER_SIZE: slot[count]={1,wr_key,wr_data}; count+1.
  - Key absent and full: write is consumed and dropped; no state change.
- count and full are registered and reflect state after each edge.
- Back-to-back extracts: allowed every cycle while no SHIFT is needed.
- Extract from an empty buffer: miss response.

Optional Feature:
- Macro: ASSOC_EXTRACT_PEEK_EN.
- When defined:
  - adds input rd_peek (1 bit, sampled with rd_valid);
  - a request with rd_peek=1 returns hit/data exactly like an extract but does not invalidate, decrement count or enter SHIFT;
  - a peek takes 1 cycle and the block stays in IDLE.
- When undefined: the port is absent and every request is an extract.

Test Plan:
- Reset, then write (A,3),(B,5),(C,7) on consecutive cycles -> count=3, full=0.
- Extract B -> next cycle rsp_valid=1, rsp_hit=1, rsp_data=5.
  - Then 1 SHIFT cycle with rd_ready=0.
  - Then count=2; extracting C returns 7.
- Extract absent key F on a 2-entry buffer -> rsp_valid=1, rsp_hit=0, rsp_data=0; count unchanged.
- Fill 4 entries, write new key E -> dropped, count=4, full=1.
  - Write existing key A with data 9, then extract A -> rsp_data=9.
- rd_valid and wr_valid asserted together in IDLE -> wr_ready=0; read serviced first; write accepted on a later IDLE cycle.
  - Extract slot 0 of a full buffer -> 3 SHIFT cycles.
  - Assert async_reset during the 2nd SHIFT cycle -> count=0, rsp_valid=0 immediately.
  - With ASSOC_EXTRACT_PEEK_EN: peek B twice -> both hit, data 5, count unchanged.
